// File: rtl/dac_spi_tx.sv
// rtl/dac_spi_tx.sv - 16-bit SPI frame transmitter for an MCP4921-class DAC with LDAC strobe
module dac_spi_tx #(
    parameter int         CLK_DIV     = 4,
    parameter logic [3:0] CONFIG_BITS = 4'b0011
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clk_en_i,
    input  logic [11:0] sample_i,
    output logic        spi_cs_n_o,
    output logic        spi_sck_o,
    output logic        spi_sdi_o,
    output logic        spi_ldac_n_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        overrun_o
);

    localparam int            DW       = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        LATCH = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    bit_q, bit_d;
    logic [15:0]   shreg_q, shreg_d;
    logic [11:0]   pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d;
    logic          cs_n_q, cs_n_d;
    logic          sck_q, sck_d;
    logic          sdi_q, sdi_d;
    logic          ldac_n_q, ldac_n_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ovr_q, ovr_d;
    logic          phase_end;
    logic          final_gap;

    assign phase_end = (div_q == DIV_LAST);
    assign final_gap = (state_q == GAP) && phase_end;

    // Next-state, datapath and registered-output decode; outputs follow the next state
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        sck_d      = sck_q;
        ovr_d      = 1'b0;

        if (state_q != IDLE) begin
            div_d = phase_end ? '0 : div_q + 1'b1;
        end

        // A strobe on the final GAP cycle is handled by the frame hand-over below
        if (clk_en_i && (state_q != IDLE) && !final_gap) begin
            pend_d     = sample_i;
            pend_vld_d = 1'b1;
            ovr_d      = pend_vld_q;
        end

        case (state_q)
            IDLE: begin
                div_d = '0;
                bit_d = '0;
                sck_d = 1'b0;
                if (clk_en_i) begin
                    shreg_d = {CONFIG_BITS, sample_i};
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (phase_end) begin
                    state_d = SHIFT;
                    bit_d   = '0;
                end
            end
            SHIFT: begin
                if (phase_end) begin
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        sck_d = 1'b0;
                        if (bit_q == 4'd15) begin
                            state_d = LATCH;
                        end else begin
                            bit_d   = bit_q + 4'd1;
                            shreg_d = {shreg_q[14:0], 1'b0};
                        end
                    end
                end
            end
            LATCH: begin
                if (phase_end) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (phase_end) begin
                    if (clk_en_i) begin
                        state_d = SETUP;
                        if (pend_vld_q) begin
                            shreg_d = {CONFIG_BITS, pend_q};
                            pend_d  = sample_i;
                        end else begin
                            shreg_d = {CONFIG_BITS, sample_i};
                        end
                    end else if (pend_vld_q) begin
                        state_d    = SETUP;
                        shreg_d    = {CONFIG_BITS, pend_q};
                        pend_vld_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cs_n_d   = !((state_d == SETUP) || (state_d == SHIFT));
        sdi_d    = cs_n_d ? 1'b0 : shreg_d[15];
        ldac_n_d = (state_d != LATCH);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == GAP) && (div_d == DIV_LAST);
    end

    // State, counters, buffers and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            cs_n_q     <= 1'b1;
            sck_q      <= 1'b0;
            sdi_q      <= 1'b0;
            ldac_n_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            cs_n_q     <= cs_n_d;
            sck_q      <= sck_d;
            sdi_q      <= sdi_d;
            ldac_n_q   <= ldac_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
        end
    end

    assign spi_cs_n_o   = cs_n_q;
    assign spi_sck_o    = sck_q;
    assign spi_sdi_o    = sdi_q;
    assign spi_ldac_n_o = ldac_n_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;
    assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb/tb_dac_spi_tx.sv - self-checking bench for dac_spi_tx at CLK_DIV=4 and CLK_DIV=1
module tb_dac_spi_tx;
    localparam int ND = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [ND-1:0] rst;
    logic [ND-1:0] clk_en;
    logic [11:0]   sample [ND];
    logic [ND-1:0] cs_n, sck, sdi, ldac_n, busy, fdone, ovr;

    dac_spi_tx #(.CLK_DIV(4), .CONFIG_BITS(4'b0011)) u_div4 (
        .clk_i(clk), .rst_i(rst[0]), .clk_en_i(clk_en[0]), .sample_i(sample[0]),
        .spi_cs_n_o(cs_n[0]), .spi_sck_o(sck[0]), .spi_sdi_o(sdi[0]), .spi_ldac_n_o(ldac_n[0]),
        .busy_o(busy[0]), .frame_done_o(fdone[0]), .overrun_o(ovr[0])
    );

    dac_spi_tx #(.CLK_DIV(1), .CONFIG_BITS(4'b0011)) u_div1 (
        .clk_i(clk), .rst_i(rst[1]), .clk_en_i(clk_en[1]), .sample_i(sample[1]),
        .spi_cs_n_o(cs_n[1]), .spi_sck_o(sck[1]), .spi_sdi_o(sdi[1]), .spi_ldac_n_o(ldac_n[1]),
        .busy_o(busy[1]), .frame_done_o(fdone[1]), .overrun_o(ovr[1])
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    function automatic int dv(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    task automatic chk(input int d, input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, expected %0h", name, d, act, exp);
        end
    endtask

    // Reference model: frame-level bookkeeping of start/end cycles and the pending slot
    int          cyc      [ND];
    bit          active   [ND];
    int          end_cyc  [ND];
    bit          pv       [ND];
    logic [11:0] pend     [ND];
    bit          exp_ovr  [ND];
    int          n_ovr_exp[ND];
    logic [15:0] expq     [ND][64];
    int          wr       [ND];
    int          rd       [ND];

    task automatic push(input int d, input logic [11:0] s);
        expq[d][wr[d] % 64] = {4'h3, s};
        wr[d]++;
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            exp_ovr[d] = 1'b0;
            if (rst[d]) begin
                active[d] = 1'b0;
                pv[d]     = 1'b0;
                rd[d]     = wr[d];
            end else if (active[d] && cyc[d] == end_cyc[d]) begin
                if (clk_en[d]) begin
                    if (pv[d]) begin
                        push(d, pend[d]);
                        pend[d] = sample[d];
                    end else begin
                        push(d, sample[d]);
                    end
                    end_cyc[d] = cyc[d] + 35 * dv(d);
                end else if (pv[d]) begin
                    push(d, pend[d]);
                    pv[d]      = 1'b0;
                    end_cyc[d] = cyc[d] + 35 * dv(d);
                end else begin
                    active[d] = 1'b0;
                end
            end else if (active[d]) begin
                if (clk_en[d]) begin
                    if (pv[d]) begin
                        exp_ovr[d] = 1'b1;
                        n_ovr_exp[d]++;
                    end
                    pend[d] = sample[d];
                    pv[d]   = 1'b1;
                end
            end else if (clk_en[d]) begin
                push(d, sample[d]);
                active[d]  = 1'b1;
                end_cyc[d] = cyc[d] + 35 * dv(d);
            end
            cyc[d]++;
        end
    end

    // Pin monitor: rebuilds words from SCK rising edges and checks frame shape
    logic [15:0] shw     [ND];
    int          nbits   [ND];
    int          hi_run  [ND];
    int          lo_run  [ND];
    int          cs_run  [ND];
    int          ldac_run[ND];
    bit          abort   [ND];
    bit          p_cs    [ND];
    bit          p_sck   [ND];
    bit          p_sdi   [ND];
    bit          p_ldac  [ND];
    logic [15:0] obs     [ND][256];
    int          nobs    [ND];
    int          ovr_seen[ND];

    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (mon_en) begin
                chk(d, "busy", busy[d], active[d]);
                chk(d, "frame_done", fdone[d], active[d] && (cyc[d] == end_cyc[d]));
                chk(d, "overrun", ovr[d], exp_ovr[d]);
                if (ovr[d]) ovr_seen[d]++;
                if (rst[d]) begin
                    abort[d] = 1'b1;
                end else if (abort[d]) begin
                    abort[d]    = 1'b0;
                    nbits[d]    = 0;
                    hi_run[d]   = 0;
                    lo_run[d]   = 0;
                    cs_run[d]   = 0;
                    ldac_run[d] = 0;
                end else begin
                    if (!ldac_n[d]) ldac_run[d]++;
                    if (ldac_n[d] && !p_ldac[d]) begin
                        chk(d, "ldac_len", ldac_run[d], dv(d));
                        ldac_run[d] = 0;
                    end
                    if (cs_n[d]) begin
                        chk(d, "idle_sck", sck[d], 0);
                        chk(d, "idle_sdi", sdi[d], 0);
                        if (!p_cs[d]) begin
                            chk(d, "cs_low_len", cs_run[d], 33 * dv(d));
                            chk(d, "ldac_at_cs_rise", ldac_n[d], 0);
                            chk(d, "last_high_run", hi_run[d], dv(d));
                            chk(d, "bit_count", nbits[d], 16);
                            if (rd[d] < wr[d]) begin
                                chk(d, "frame_word", shw[d], expq[d][rd[d] % 64]);
                                rd[d]++;
                            end else begin
                                chk(d, "frame_unexpected", 1, 0);
                            end
                            obs[d][nobs[d] % 256] = shw[d];
                            nobs[d]++;
                        end
                        nbits[d]  = 0;
                        cs_run[d] = 0;
                        lo_run[d] = 0;
                        hi_run[d] = 0;
                    end else begin
                        cs_run[d]++;
                        if (sck[d] && !p_sck[d]) begin
                            chk(d, "sck_low_run", lo_run[d], (nbits[d] == 0) ? 2 * dv(d) : dv(d));
                            shw[d] = {shw[d][14:0], sdi[d]};
                            nbits[d]++;
                            hi_run[d] = 1;
                        end else if (sck[d]) begin
                            chk(d, "sdi_stable", sdi[d], p_sdi[d]);
                            hi_run[d]++;
                        end else if (p_sck[d]) begin
                            chk(d, "sck_high_run", hi_run[d], dv(d));
                            lo_run[d] = 1;
                        end else begin
                            lo_run[d]++;
                        end
                    end
                end
            end
            p_cs[d]   = cs_n[d];
            p_sck[d]  = sck[d];
            p_sdi[d]  = sdi[d];
            p_ldac[d] = ldac_n[d];
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input int d, input logic [11:0] s, output int t);
        clk_en[d] = 1'b1;
        sample[d] = s;
        t = cyc[d];
        @(posedge clk);
        #1;
        clk_en[d] = 1'b0;
        sample[d] = 12'($urandom);
    endtask

    task automatic wait_done(input int d, output int at);
        at = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (fdone[d]) begin
                at = cyc[d];
                break;
            end
        end
        if (at < 0) chk(d, "done_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          d;
        logic [11:0] s;
        logic [15:0] w;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int t, t2, a1, a2, a3, o0;

        vecs[0] = '{0, 12'hABC, 16'h3ABC};
        vecs[1] = '{0, 12'h000, 16'h3000};
        vecs[2] = '{0, 12'hFFF, 16'h3FFF};
        vecs[3] = '{1, 12'h000, 16'h3000};
        vecs[4] = '{1, 12'hFFF, 16'h3FFF};
        vecs[5] = '{1, 12'h5A3, 16'h35A3};

        rst       = '1;
        clk_en    = '0;
        sample[0] = '0;
        sample[1] = '0;
        tick(3);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk(d, "rst_cs_n", cs_n[d], 1);
            chk(d, "rst_sck", sck[d], 0);
            chk(d, "rst_sdi", sdi[d], 0);
            chk(d, "rst_ldac_n", ldac_n[d], 1);
            chk(d, "rst_busy", busy[d], 0);
            chk(d, "rst_frame_done", fdone[d], 0);
            chk(d, "rst_overrun", ovr[d], 0);
        end
        @(posedge clk);
        #1;
        rst    = '0;
        mon_en = 1'b1;
        tick(2);

        for (int i = 0; i < 6; i++) begin
            strobe(vecs[i].d, vecs[i].s, t);
            wait_done(vecs[i].d, a1);
            chk(vecs[i].d, "vec_period", a1 - t, 35 * dv(vecs[i].d));
            chk(vecs[i].d, "vec_word", obs[vecs[i].d][(nobs[vecs[i].d] - 1) % 256], vecs[i].w);
            tick(3);
        end

        // Back-to-back: second strobe mid-frame, second SETUP right after GAP
        o0 = ovr_seen[0];
        strobe(0, 12'h123, t);
        tick(49);
        strobe(0, 12'h456, t2);
        wait_done(0, a1);
        wait_done(0, a2);
        chk(0, "b2b_first_done", a1 - t, 140);
        chk(0, "b2b_period", a2 - a1, 140);
        chk(0, "b2b_word0", obs[0][(nobs[0] - 2) % 256], 16'h3123);
        chk(0, "b2b_word1", obs[0][(nobs[0] - 1) % 256], 16'h3456);
        chk(0, "b2b_no_overrun", ovr_seen[0] - o0, 0);
        tick(3);

        // Overrun: latest pending sample wins
        o0 = ovr_seen[0];
        strobe(0, 12'h111, t);
        tick(10);
        strobe(0, 12'h222, t2);
        tick(10);
        strobe(0, 12'h333, t2);
        wait_done(0, a1);
        wait_done(0, a2);
        chk(0, "ovr_count", ovr_seen[0] - o0, 1);
        chk(0, "ovr_word0", obs[0][(nobs[0] - 2) % 256], 16'h3111);
        chk(0, "ovr_word1", obs[0][(nobs[0] - 1) % 256], 16'h3333);
        tick(3);

        // Strobe on the final GAP cycle with a sample already pending
        o0 = ovr_seen[0];
        strobe(0, 12'h0CC, t);
        tick(20);
        strobe(0, 12'h0AA, t2);
        tick(t + 140 - cyc[0]);
        strobe(0, 12'h0BB, t2);
        chk(0, "coll_strobe_cycle", t2 - t, 140);
        wait_done(0, a1);
        wait_done(0, a2);
        chk(0, "coll_period", a2 - a1, 140);
        chk(0, "coll_word0", obs[0][(nobs[0] - 3) % 256], 16'h30CC);
        chk(0, "coll_word1", obs[0][(nobs[0] - 2) % 256], 16'h30AA);
        chk(0, "coll_word2", obs[0][(nobs[0] - 1) % 256], 16'h30BB);
        chk(0, "coll_no_overrun", ovr_seen[0] - o0, 0);
        tick(3);

        // Reset after bit 7 of the frame, then a clean frame
        a3 = nobs[0];
        strobe(0, 12'h7E5, t);
        tick(71);
        rst[0] = 1'b1;
        tick(1);
        rst[0] = 1'b0;
        @(negedge clk);
        chk(0, "abort_cs_n", cs_n[0], 1);
        chk(0, "abort_sck", sck[0], 0);
        chk(0, "abort_ldac_n", ldac_n[0], 1);
        chk(0, "abort_busy", busy[0], 0);
        @(posedge clk);
        #1;
        tick(2);
        strobe(0, 12'h3C3, t);
        wait_done(0, a1);
        chk(0, "after_abort_period", a1 - t, 140);
        chk(0, "after_abort_frames", nobs[0] - a3, 1);
        chk(0, "after_abort_word", obs[0][(nobs[0] - 1) % 256], 16'h33C3);
        tick(3);

        // Random strobes on both instances against the model
        for (int c = 0; c < 3000; c++) begin
            clk_en[0] = ($urandom_range(0, 99) < 1);
            clk_en[1] = ($urandom_range(0, 99) < 4);
            sample[0] = 12'($urandom);
            sample[1] = 12'($urandom);
            tick(1);
        end
        clk_en = '0;
        tick(400);
        for (int d = 0; d < ND; d++) begin
            chk(d, "drain_all_frames", rd[d], wr[d]);
            chk(d, "overrun_total", ovr_seen[d], n_ovr_exp[d]);
            chk(d, "idle_at_end", busy[d], 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

Serial transmitter for the 12-bit DAC code produced by the output mixer. It captures one sample per `clk_en` strobe and shifts it MSB-first as a 16-bit SPI frame (4 config bits + 12 data bits) to an MCP4921-class DAC. It then pulses LDAC so the analog output updates on a sample-aligned edge. It sits between the mixer's `dac_output` and the board-level DAC pins, and provides a one-deep pending buffer plus overrun reporting.

## Interface
- `CLK_DIV`, 4: SCK half-period in `clk` cycles; legal range ≥1.
- `CONFIG_BITS`, 4'b0011: frame bits [15:12] (A/B̅=0, BUF=0, GA̅=1 (1×), SHDN̅=1).

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `clk_en`  in  1  sample strobe, one cycle wide.
- `sample`  in  12  unsigned DAC code, valid when `clk_en`=1.
- `spi_cs_n`  out  1  chip select, active low.
- `spi_sck`  out  1  serial clock, SPI mode 0, idle low.
- `spi_sdi`  out  1  serial data to DAC.
- `spi_ldac_n`  out  1  latch strobe, active low.
- `busy`  out  1  high whenever the state is not IDLE.
- `frame_done`  out  1  one-cycle pulse on the last cycle of a frame.
- `overrun`  out  1  one-cycle pulse when a pending sample is discarded.

## Operation
- **Outputs:** all outputs are registered.
  - Reset values: `spi_cs_n`=1, `spi_sck`=0, `spi_sdi`=0, `spi_ldac_n`=1, `busy`=0, `frame_done`=0, `overrun`=0.
  - Reset also clears the pending buffer, and the state goes to IDLE.
- **Frame word:** `{CONFIG_BITS, sample}`, transmitted bit 15 first.
- **States:**
  - IDLE: `cs_n`=1, `sck`=0.
    - `clk_en`=1 → load the shift register with the frame word → SETUP.
  - SETUP: `cs_n`=0, `sck`=0, `sdi`=bit 15. Lasts `CLK_DIV` cycles → SHIFT.
  - SHIFT: 16 bits, 2·`CLK_DIV` cycles per bit.
    - The first `CLK_DIV` cycles have `sck`=0; the next `CLK_DIV` cycles have `sck`=1.
    - `sdi` changes only on the cycle `sck` falls, i.e. the start of the next bit's low phase.
    - The DAC samples on the rising edge.
    - After the 16th high phase → LATCH.
  - LATCH: `cs_n`=1, `sck`=0, `ldac_n`=0. Lasts `CLK_DIV` cycles → GAP.
  - GAP: all lines idle; `sdi`=0. Lasts `CLK_DIV` cycles.
    - `frame_done`=1 on its final cycle.
    - Next state is SETUP if the pending buffer is valid (load the pending word, clear valid); otherwise IDLE.
- **Pending buffer (1 deep):** `clk_en` while `busy`=1 stores `sample` and sets valid.
  - If valid was already set, the old pending sample is overwritten (latest wins) and `overrun` pulses on the next cycle.
- **`clk_en` on the final GAP cycle:** the pending word (if any) is consumed into the shift register, and the new sample becomes pending with valid=1.
  - `overrun` does not pulse in this case.
  - If nothing was pending, the new sample starts the next frame directly.
- **Reset mid-frame:** abort the frame; `cs_n` rises on the cycle after `rst`. The DAC discards frames shorter than 16 clocks, so the previous analog value holds.
- **Counters:** divider width is ⌈log2(`CLK_DIV`+1)⌉ and the bit counter is 4 bits; neither wraps outside its state.

## Timing
- `clk_en` at cycle T in IDLE → `spi_cs_n`=0 and `busy`=1 at T+1.
- `cs_n` low for 33·`CLK_DIV` cycles. `ldac_n` low for `CLK_DIV` cycles, starting on the same cycle `cs_n` rises.
- Frame period is 35·`CLK_DIV` cycles (140 at the default).
  - Back-to-back frames have no extra idle cycles: the next SETUP follows GAP directly.
- `frame_done` occurs at T+35·`CLK_DIV`; `busy` falls the cycle after (if nothing is pending).
- Sustained sample rate must be ≤ f_clk/(35·`CLK_DIV`), otherwise overruns occur.

## Test plan
- **Single frame:** `CLK_DIV`=4, `sample`=12'hABC → `sdi` on 16 SCK rising edges = 0011_1010_1011_1100.
  - `cs_n` low for 132 cycles, then `ldac_n` low for 4 cycles.
  - `frame_done` at T+140.
- **Back-to-back:** `clk_en` with 12'h123, then 12'h456 at T+50 → second SETUP immediately follows GAP; second frame carries 0x3456; no `overrun`.
- **Overrun:** strobes 12'h111, 12'h222, 12'h333 within one frame → one `overrun` pulse; frames sent are 0x3111 then 0x3333.
- **End-of-frame collision:** `clk_en` on the final GAP cycle with pending 12'h0AA and new 12'h0BB → frames 0x30AA then 0x30BB; no `overrun`.
- **Reset mid-frame:** `rst` asserted after bit 7 → next cycle `cs_n`=1, `sck`=0, `ldac_n`=1, `busy`=0; the next strobe starts a clean frame.
- **Minimum divider:** `CLK_DIV`=1 with 12'h000 and 12'hFFF → frame period 35 cycles; words 0x3000 and 0x3FFF; SCK toggles every cycle during SHIFT.
